// File: rtl/uart_wb_bridge.sv
// uart_wb_bridge: UART byte command responder driving one Wishbone master; UARTBRIDGE_TIMEOUT_EN adds a bus ack timeout
module uart_wb_bridge #(
    parameter int timeout = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_avail,
    output logic        rx_ack,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_SEND} state_t;
    state_t      r_state, w_next;
    logic [7:0]  r_cmd, r_tx_data;
    logic [1:0]  r_cnt;
    logic [31:0] r_adr, r_dat, r_reply;
    logic [2:0]  r_nleft;
    logic        r_rx_ack, r_tx_wr, r_tx_wr_d;
    logic        w_take, w_send, w_to, w_rw;
    assign w_take = (r_state == S_IDLE || r_state == S_ADDR || r_state == S_DATA) && rx_avail && !r_rx_ack;
    assign w_send = r_state == S_SEND && !tx_busy && !r_tx_wr && !r_tx_wr_d;
    assign w_rw   = rx_data == 8'h72 || rx_data == 8'h77;
`ifdef UARTBRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(timeout + 1);
    logic [TW-1:0] r_to_cnt;
    always_ff @(posedge clk)
        r_to_cnt <= (reset || r_state != S_BUS) ? '0 : r_to_cnt + 1'b1;
    // an ack arriving in the final cycle still wins over the timeout
    assign w_to = r_state == S_BUS && !wb_ack_i && r_to_cnt == TW'(timeout - 1);
`else
    assign w_to = 1'b0;
`endif
    always_ff @(posedge clk)
        r_state <= reset ? S_IDLE : w_next;
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_take) w_next = w_rw ? S_ADDR : S_SEND;
            S_ADDR: if (w_take && &r_cnt) w_next = r_cmd == 8'h77 ? S_DATA : S_BUS;
            S_DATA: if (w_take && &r_cnt) w_next = S_BUS;
            S_BUS:  if (wb_ack_i || w_to) w_next = S_SEND;
            S_SEND: if (w_send && r_nleft == 3'd1) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd     <= '0;
            r_cnt     <= '0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_reply   <= '0;
            r_nleft   <= '0;
            r_rx_ack  <= 1'b0;
            r_tx_wr   <= 1'b0;
            r_tx_wr_d <= 1'b0;
            r_tx_data <= '0;
        end else begin
            r_rx_ack  <= w_take;
            r_tx_wr   <= w_send;
            r_tx_wr_d <= r_tx_wr;
            if (w_take && r_state == S_IDLE) begin
                r_cmd   <= rx_data;
                r_cnt   <= '0;
                r_reply <= {rx_data == 8'h70 ? 8'h50 : 8'h3F, 24'h0};
                r_nleft <= 3'd1;
            end else if (w_take && r_state == S_ADDR) begin
                r_adr <= {r_adr[23:0], rx_data};
                r_cnt <= r_cnt + 2'd1;
            end else if (w_take && r_state == S_DATA) begin
                r_dat <= {r_dat[23:0], rx_data};
                r_cnt <= r_cnt + 2'd1;
            end
            if (r_state == S_BUS && wb_ack_i) begin
                r_reply <= r_cmd == 8'h72 ? wb_dat_i : {8'h6B, 24'h0};
                r_nleft <= r_cmd == 8'h72 ? 3'd4 : 3'd1;
            end else if (w_to) begin
                r_reply <= {8'h21, 24'h0};
                r_nleft <= 3'd1;
            end
            if (w_send) begin
                r_tx_data <= r_reply[31:24];
                r_reply   <= {r_reply[23:0], 8'h0};
                r_nleft   <= r_nleft - 3'd1;
            end
        end
    end
    assign rx_ack   = r_rx_ack;
    assign tx_wr    = r_tx_wr;
    assign tx_data  = r_tx_data;
    assign wb_cyc_o = r_state == S_BUS;
    assign wb_stb_o = r_state == S_BUS;
    assign wb_we_o  = r_state == S_BUS && r_cmd == 8'h77;
    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_dat;
    assign wb_sel_o = 4'b1111;
endmodule

// File: tb/tb_uart_wb_bridge.sv
// tb_uart_wb_bridge: directed bench with reply scoreboard, UART/Wishbone models for uart_wb_bridge
module tb_uart_wb_bridge;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_avail = 1'b0;
    logic        rx_ack;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy = 1'b0;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_stb_o, wb_cyc_o;
    logic        wb_ack_i = 1'b0;
    int errors = 0, checks = 0;
    logic [8:0] exp_q[$];
    logic [8:0] exp_b;
    int ws = 0, busy_len = 0, busy_left = 0, no_ack = 0, ws_cnt = 0;
    int bus_cnt = 0, cyc_len = 0, tx_cnt = 0, bus_before = 0;
    logic busy_s, stable = 1'b1, cyc_prev = 1'b0, rx_ack_prev = 1'b0, tx_wr_prev = 1'b0;
    logic [31:0] adr_s = 0, dat_s = 0;
    logic we_s = 0;
    logic [3:0] sel_s = 0;

    uart_wb_bridge #(.timeout(16)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_avail(rx_avail), .rx_ack(rx_ack),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // transmitter model: checks each reply byte and goes busy after it
    always @(posedge clk) begin
        busy_s = tx_busy;
        #1;
        if (tx_wr) begin
            tx_cnt++;
            if (exp_q.size() != 0) exp_b = exp_q.pop_front();
            else exp_b = 9'h100;
            chk("tx_byte", {24'h0, tx_data}, {23'h0, exp_b});
            chk("tx_busy_idle", {31'h0, busy_s}, 32'h0);
            chk("tx_wr_pulse", {31'h0, tx_wr_prev}, 32'h0);
            if (busy_len > 0) begin
                tx_busy = 1'b1;
                busy_left = busy_len;
            end
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) tx_busy = 1'b0;
        end
        if (rx_ack) chk("rx_ack_pulse", {31'h0, rx_ack_prev}, 32'h0);
        rx_ack_prev = rx_ack;
        tx_wr_prev = tx_wr;
    end

    // Wishbone slave with programmable wait states, plus cycle recorder
    always @(posedge clk) begin
        #1;
        if (wb_cyc_o) begin
            if (!cyc_prev) begin
                bus_cnt++;
                cyc_len = 0;
                adr_s = wb_adr_o;
                dat_s = wb_dat_o;
                we_s = wb_we_o;
                sel_s = wb_sel_o;
                stable = 1'b1;
            end
            cyc_len++;
            if (wb_adr_o !== adr_s || wb_dat_o !== dat_s || wb_we_o !== we_s || wb_sel_o !== sel_s || wb_stb_o !== 1'b1)
                stable = 1'b0;
        end
        cyc_prev = wb_cyc_o;
        if (wb_ack_i) wb_ack_i = 1'b0;
        else if (wb_cyc_o && no_ack == 0) begin
            if (ws_cnt >= ws) begin
                wb_ack_i = 1'b1;
                ws_cnt = 0;
            end else ws_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_avail = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (rx_ack) break;
        end
        chk("rx_ack_seen", {31'h0, rx_ack}, 32'h1);
        rx_avail = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (20) @(posedge clk);
        #1;
        chk("tx_drain", exp_q.size(), 32'h0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_ack", {31'h0, rx_ack}, 32'h0);
        chk("rst_tx_wr", {31'h0, tx_wr}, 32'h0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
        chk("rst_cyc", {31'h0, wb_cyc_o}, 32'h0);
        chk("rst_stb", {31'h0, wb_stb_o}, 32'h0);
        chk("rst_we", {31'h0, wb_we_o}, 32'h0);
        chk("rst_adr", wb_adr_o, 32'h0);
        chk("rst_dat", wb_dat_o, 32'h0);
        chk("rst_sel", {28'h0, wb_sel_o}, 32'hF);
        reset = 1'b0;
        exp_q.push_back(9'h50);
        send_byte(8'h70);
        wait_drain();
        chk("ping_no_bus", bus_cnt, 32'h0);
        chk("ping_tx_cnt", tx_cnt, 32'h1);
        exp_q.push_back(9'h6B);
        send_byte(8'h77);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h00);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        wait_drain();
        chk("wr_bus_cnt", bus_cnt, 32'h1);
        chk("wr_adr", adr_s, 32'h00001000);
        chk("wr_dat", dat_s, 32'hDEADBEEF);
        chk("wr_we", {31'h0, we_s}, 32'h1);
        chk("wr_sel", {28'h0, sel_s}, 32'hF);
        chk("wr_len", cyc_len, 32'h1);
        chk("wr_stable", {31'h0, stable}, 32'h1);
        ws = 3;
        busy_len = 5;
        wb_dat_i = 32'h12345678;
        exp_q.push_back(9'h12);
        exp_q.push_back(9'h34);
        exp_q.push_back(9'h56);
        exp_q.push_back(9'h78);
        send_byte(8'h72);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'h04);
        wait_drain();
        chk("rd_bus_cnt", bus_cnt, 32'h2);
        chk("rd_adr", adr_s, 32'h00002004);
        chk("rd_we", {31'h0, we_s}, 32'h0);
        chk("rd_len", cyc_len, 32'h4);
        chk("rd_stable", {31'h0, stable}, 32'h1);
        chk("rd_tx_cnt", tx_cnt, 32'h6);
        exp_q.push_back(9'h3F);
        exp_q.push_back(9'h50);
        send_byte(8'h67);
        send_byte(8'h70);
        wait_drain();
        chk("unk_bus_cnt", bus_cnt, 32'h2);
        bus_before = bus_cnt;
        send_byte(8'h77);
        send_byte(8'h00);
        send_byte(8'h00);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_rst_cyc", {31'h0, wb_cyc_o}, 32'h0);
        exp_q.push_back(9'h50);
        send_byte(8'h70);
        wait_drain();
        chk("mid_rst_no_bus", bus_cnt, bus_before);
        chk("mid_rst_tx_cnt", tx_cnt, 32'h9);
`ifdef UARTBRIDGE_TIMEOUT_EN
        no_ack = 1;
        busy_len = 0;
        exp_q.push_back(9'h21);
        send_byte(8'h72);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h40);
        wait_drain();
        chk("to_bus_cnt", bus_cnt, bus_before + 1);
        chk("to_len", cyc_len, 32'd16);
        no_ack = 0;
        exp_q.push_back(9'h50);
        send_byte(8'h70);
        wait_drain();
        chk("to_ping_tx_cnt", tx_cnt, 32'd11);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
